tff_counter: RTL and testbench
==============================

TFF_COUNTER -- requirements
Module: tff_counter

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 4: the counter bit width, legal range 1..16.
REQ-002 The block SHALL provide parameter MODULUS, default 2**WIDTH: the count range 0..MODULUS-1, legal range 2..2**WIDTH; an illegal value SHALL stop elaboration.
REQ-003 The block SHALL provide port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL provide port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL provide port en, input, 1 bit: count enable.
REQ-006 The block SHALL provide port up, input, 1 bit: direction, 1 = increment, 0 = decrement.
REQ-007 The block SHALL provide port load, input, 1 bit: synchronous parallel load (present only when TFF_COUNTER_LOAD_EN is defined).
REQ-008 The block SHALL provide port d, input, WIDTH bits: load value (present only when TFF_COUNTER_LOAD_EN is defined).
REQ-009 The block SHALL provide port q, output, WIDTH bits: current count.
REQ-010 The block SHALL provide port nq, output, WIDTH bits: bitwise complement of q at all times.
REQ-011 The block SHALL provide port tc, output, 1 bit: terminal count, combinational.

Function
REQ-012 Per rising clock edge, priority SHALL be reset > load > en > hold.
REQ-013 With en=1, up=1: q SHALL go to q+1, or to 0 when q==MODULUS-1 (wrap).
REQ-014 With en=1, up=0: q SHALL go to q-1, or to MODULUS-1 when q==0 (wrap).
REQ-015 With en=0 and no load: q SHALL hold.
REQ-016 With load=1: q SHALL take d on the next edge regardless of en and up.
REQ-017 A load value d>=MODULUS SHALL be clamped, so q becomes MODULUS-1.
REQ-018 tc SHALL equal en & ((up & q==MODULUS-1) | (~up & q==0)).
REQ-019 tc SHALL be forced to 0 while load=1 or reset=1.
REQ-020 Count latency SHALL be one edge: q updates on the same edge that samples en/load.
REQ-021 A direction change SHALL take effect on the edge where the new up is sampled, with no extra delay cycle.
REQ-022 q SHALL never hold a value >= MODULUS, except transiently before the first reset.

Reset
REQ-023 reset=1 SHALL immediately, with no clock, force q=0, nq=all ones and tc=0.
REQ-024 Deasserting reset SHALL take effect at the first rising edge after deassertion; the count resumes from 0.
REQ-025 Asserting reset mid-count SHALL discard any load or count pending on that edge.

Configuration
REQ-026 Macro TFF_COUNTER_LOAD_EN defined: ports load and d SHALL exist and REQ-016 and REQ-017 apply.
REQ-027 Macro TFF_COUNTER_LOAD_EN undefined: load and d SHALL be absent, load is treated as 0, and the counter only counts, holds or resets.

Structure
REQ-028 Package tff_counter_pkg SHALL hold the default WIDTH constant and the maximum legal WIDTH constant.
REQ-029 Each state bit SHALL be one instance of sub-module tff_reset: a T flip-flop with asynchronous active-high reset and outputs Q/nQ.
REQ-030 A combinational next-toggle network SHALL drive the T inputs from q, en, up, load, d and the wrap detection.
REQ-031 No other storage elements SHALL exist besides the tff_reset instances.

Verification
REQ-032 WIDTH=4, MODULUS=10: reset, then en=1, up=1 for 12 edges -> q = 1..9,0,1,2; tc=1 only while q==9.
REQ-033 WIDTH=4, MODULUS=10: from q=0, en=1, up=0 for 3 edges -> q = 9,8,7; tc=1 in the cycle q==0.
REQ-034 WIDTH=4, MODULUS=16, q=5: assert reset between edges -> q=0 and nq=4'hF immediately; after release with en=1 -> q=1 on the next edge.
REQ-035 LOAD_EN build, MODULUS=10: load=1, d=7, en=1 -> q=7 and tc=0; next, load=1, d=12 -> q=9 (clamped).
REQ-036 q=3, en=1 toggling up each edge -> q = 4,3,4,3; en=0 for 2 edges -> q holds at 3.
REQ-037 Random stimulus over 1000 cycles -> nq==~q every cycle, q<MODULUS every cycle, and the sequence matches a reference model.

Source files
------------

// File: rtl/tff_counter_pkg.sv
// Shared constants for the T-flip-flop based modulo up/down counter.
// Optional parallel load is enabled with TFF_COUNTER_LOAD_EN.
package tff_counter_pkg;

   localparam int TFF_WIDTH_DEFAULT = 4;
   localparam int TFF_WIDTH_MAX     = 16;

   function automatic bit tff_params_ok(input int width, input int modulus);
      return (width >= 1) && (width <= TFF_WIDTH_MAX) &&
             (modulus >= 2) && (modulus <= (2 ** width));
   endfunction

endpackage

// File: rtl/tff_counter_tff_reset.sv
// Single T flip-flop with asynchronous active-high reset.
// Instanced once per counter state bit.
module tff_reset (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_t,
   output logic o_q,
   output logic o_nq
);

   logic r_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_q <= 1'b0;
      else if (i_t)
         r_q <= ~r_q;
   end

   assign o_q  = r_q;
   assign o_nq = ~r_q;

endmodule

// File: rtl/tff_counter.sv
// Modulo up/down counter built from T flip-flops and a toggle network.
// Define TFF_COUNTER_LOAD_EN to add the synchronous parallel load (load, d).
import tff_counter_pkg::*;

module tff_counter #(
   parameter int WIDTH   = TFF_WIDTH_DEFAULT,
   parameter int MODULUS = 2 ** WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
`ifdef TFF_COUNTER_LOAD_EN
   input  logic             load,
   input  logic [WIDTH-1:0] d,
`endif
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] nq,
   output logic             tc
);

   if (!tff_params_ok(WIDTH, MODULUS)) begin : g_bad_params
      $fatal(1, "tff_counter: illegal WIDTH/MODULUS");
   end

   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   logic             w_load;
   logic [WIDTH-1:0] w_d;
   logic [WIDTH-1:0] w_d_clamp;
   logic [WIDTH-1:0] w_next;
   logic [WIDTH-1:0] w_t;
   logic             w_at_max;
   logic             w_at_zero;

`ifdef TFF_COUNTER_LOAD_EN
   assign w_load = load;
   assign w_d    = d;
`else
   assign w_load = 1'b0;
   assign w_d    = '0;
`endif

   assign w_at_max  = (q == MAXV);
   assign w_at_zero = (q == '0);
   assign w_d_clamp = (w_d > MAXV) ? MAXV : w_d;

   always_comb begin
      w_next = q;
      if (w_load)
         w_next = w_d_clamp;
      else if (en && up)
         w_next = w_at_max ? '0 : q + ONE;
      else if (en)
         w_next = w_at_zero ? MAXV : q - ONE;
   end

   // A T flop toggles exactly where the target differs from the present bit.
   assign w_t = w_next ^ q;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      tff_reset u_tff (
         .i_clk (clock),
         .i_rst (reset),
         .i_t   (w_t[i]),
         .o_q   (q[i]),
         .o_nq  (nq[i])
      );
   end

   assign tc = en & ~w_load & ~reset &
               ((up & w_at_max) | (~up & w_at_zero));

endmodule

// File: tb/tb_tff_counter.sv
// Randomized and directed bench for tff_counter (WIDTH=4, MODULUS=10).
// Load checks run only when TFF_COUNTER_LOAD_EN is defined.
module tb_tff_counter;

   localparam int W   = 4;
   localparam int MOD = 10;
`ifdef TFF_COUNTER_LOAD_EN
   localparam bit HAS_LOAD = 1'b1;
`else
   localparam bit HAS_LOAD = 1'b0;
`endif

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         en    = 1'b0;
   logic         up    = 1'b1;
   logic         load  = 1'b0;
   logic [W-1:0] d     = '0;
   logic [W-1:0] q;
   logic [W-1:0] nq;
   logic         tc;

   int n_cmp = 0;
   int n_err = 0;
   int m_q   = 0;

   tff_counter #(.WIDTH(W), .MODULUS(MOD)) dut (
      .clock (clock),
      .reset (reset),
      .en    (en),
      .up    (up),
`ifdef TFF_COUNTER_LOAD_EN
      .load  (load),
      .d     (d),
`endif
      .q     (q),
      .nq    (nq),
      .tc    (tc)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   // One cycle: drive at negedge, check tc before the edge, q after it.
   task automatic step(input bit r, input bit e, input bit u,
                       input bit l, input int dv);
      bit ld;
      bit exp_tc;
      @(negedge clock);
      reset = r;
      en    = e;
      up    = u;
      load  = l;
      d     = W'(dv);
      ld    = HAS_LOAD && l;
      #1;
      exp_tc = !r && e && !ld &&
               ((u && m_q == MOD - 1) || (!u && m_q == 0));
      chk("tc", int'(tc), int'(exp_tc));
      if (r) chk("q_async_rst", int'(q), 0);
      @(posedge clock);
      #1;
      if (r)
         m_q = 0;
      else if (ld)
         m_q = (dv >= MOD) ? MOD - 1 : dv;
      else if (e && u)
         m_q = (m_q + 1) % MOD;
      else if (e)
         m_q = (m_q + MOD - 1) % MOD;
      chk("q", int'(q), m_q);
      chk("nq", int'(nq), int'(~q) & 15);
      chk("q_range", int'(q < W'(MOD)), 1);
   endtask

   initial begin
      #1;
      chk("rst_q", int'(q), 0);
      chk("rst_nq", int'(nq), 15);
      chk("rst_tc", int'(tc), 0);

      // Up count with wrap at 9
      for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 0);
      chk("up12_q", int'(q), 2);

      // Down from 0 wraps to 9
      step(1, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
      chk("down3_q", int'(q), 7);

      // Mid-cycle asynchronous reset from q=5
      step(1, 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0);
      chk("pre_rst_q", int'(q), 5);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_q", int'(q), 0);
      chk("mid_rst_nq", int'(nq), 15);
      chk("mid_rst_tc", int'(tc), 0);
      m_q = 0;
      step(0, 1, 1, 0, 0);
      chk("post_rst_q", int'(q), 1);

      // Direction toggling then hold
      step(0, 1, 1, 0, 0);
      step(0, 1, 1, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 1, (i % 2) == 0, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("hold_q", int'(q), 3);

      if (HAS_LOAD) begin
         step(0, 1, 1, 1, 7);
         chk("load7_q", int'(q), 7);
         step(0, 1, 0, 1, 12);
         chk("load12_q", int'(q), 9);
      end

      // Randomized traffic
      for (int i = 0; i < 1000; i++) begin
         step($urandom_range(0, 49) == 0,
              $urandom_range(0, 3) != 0,
              1'($urandom),
              $urandom_range(0, 7) == 0,
              int'($urandom_range(0, 15)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
